// File: rtl/fifo_unpack.sv
// fifo_unpack: pops 36-bit FWFT words and streams the unmasked
// bytes lowest-first on an 8-bit valid/ready port, in bursts.
module fifo_unpack #(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [35:0]      FIFO_DO,
  input  logic             FIFO_EMPTY,
  input  logic             FIFO_ALMOSTEMPTY,
  output logic             FIFO_RDEN,
  input  logic             FLUSH,
  output logic [7:0]       BYTE,
  output logic             BYTE_VALID,
  input  logic             BYTE_READY,
  output logic             BUSY,
  output logic [CNT_W-1:0] WORDS
);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [15:0]      tmo_q, tmo_d;
  logic [31:0]      data_q, data_d;
  logic [3:0]       mask_q, mask_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] words_q, words_d;

  logic       draining;
  logic       accept;
  logic       xfer;
  logic       hold_free;
  logic       pop;
  logic [3:0] mask_rest;
  logic [1:0] sel;
  logic [7:0] sel_byte;

  // Holding mask tracks bytes not yet moved to the output register,
  // so a pop can overlap the move of the last byte (no bubble).
  assign draining  = (state_q == DRAIN);
  assign accept    = valid_q & BYTE_READY;
  assign mask_rest = mask_q & (mask_q - 4'd1);
  assign xfer      = draining & (|mask_q) & (~valid_q | BYTE_READY);
  assign hold_free = (mask_q == 4'd0) | (xfer & (mask_rest == 4'd0));
  assign pop       = draining & ~FIFO_EMPTY & hold_free;

  // Pick the lowest still-pending byte of the held word.
  always_comb begin
    if (mask_q[0])      sel = 2'd0;
    else if (mask_q[1]) sel = 2'd1;
    else if (mask_q[2]) sel = 2'd2;
    else                sel = 2'd3;
  end

  assign sel_byte = data_q[{sel, 3'b000} +: 8];

  // Next-state: byte handoff, word load, burst gating.
  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    mask_d  = mask_q;
    byte_d  = byte_q;
    valid_d = valid_q;
    words_d = words_q;
    if (accept) valid_d = 1'b0;
    if (xfer) begin
      valid_d = 1'b1;
      byte_d  = sel_byte;
      mask_d  = mask_rest;
    end
    if (pop) begin
      data_d  = FIFO_DO[31:0];
      mask_d  = FIFO_DO[35:32];
      words_d = words_q + CNT_W'(1);
    end
    unique case (state_q)
      IDLE: begin
        if (FIFO_EMPTY) begin
          tmo_d = 16'd0;
        end else if (!FIFO_ALMOSTEMPTY || FLUSH ||
                     tmo_q == TO_LAST) begin
          state_d = DRAIN;
          tmo_d   = 16'd0;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      DRAIN: begin
        if (mask_q == 4'd0 && (!valid_q || BYTE_READY) &&
            FIFO_EMPTY) begin
          state_d = IDLE;
          tmo_d   = 16'd0;
        end
      end
    endcase
  end

  // State and output registers; reset drops any partial word.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      tmo_q   <= 16'd0;
      data_q  <= 32'd0;
      mask_q  <= 4'd0;
      byte_q  <= 8'd0;
      valid_q <= 1'b0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      words_q <= words_d;
    end
  end

  assign FIFO_RDEN  = pop;
  assign BYTE       = byte_q;
  assign BYTE_VALID = valid_q;
  assign BUSY       = draining;
  assign WORDS      = words_q;

endmodule
